// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
//
// Provides NUM_RD combinational read ports, two synchronous write ports (B wins
// on a same-address collision) and a sequenced bulk-clear engine. The engine
// zeroes one entry per cycle, so architectural state can be flushed without
// asserting reset.
//
// Optional feature: define REGFILE_BYPASS_EN to forward accepted write data to
// any read port addressing the same entry in the same cycle.
//
// Parameters:
//   DATA_W   - entry width
//   ADDR_W   - address width, DEPTH = 2**ADDR_W
//   NUM_RD   - number of read ports (1..8)
//   ZERO_REG - 1: entry 0 reads as zero and writes to it are discarded
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   rd_addr/rd_data   - packed read ports, port i at [i*ADDR_W +: ADDR_W] / [i*DATA_W +: DATA_W]
//   wa_*/wb_*         - write ports A and B (enable, address, data)
//   wr_ready          - writes accepted this cycle (no clear in progress)
//   clr_req           - single-cycle bulk-clear request
//   clr_busy          - clear sequence in progress
//   clr_done          - one-cycle pulse after the last entry is cleared
//   drop_err          - sticky: a write arrived while busy and was discarded
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     wr_ready,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     drop_err
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  logic                state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wa_acc;
  logic                wb_acc;

  assign clr_busy = (state == ST_CLEAR);
  assign wr_ready = ~clr_busy;

  // A write is accepted only when the array is not being cleared and, with a
  // hardwired zero entry, it does not target address 0.
  assign wa_acc = wa_en & wr_ready & ~((ZERO_REG != 0) && (wa_addr == '0));
  assign wb_acc = wb_en & wr_ready & ~((ZERO_REG != 0) && (wb_addr == '0));

  // Clear sequencer and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      clr_ptr  <= '0;
      clr_done <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      if (clr_busy && (wa_en || wb_en)) begin
        drop_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
          end
        end
        ST_CLEAR: begin
          // Pointer wraps back to 0 on the final entry, ready for the next run.
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == LAST_PTR) begin
            state    <= ST_IDLE;
            clr_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Storage array.
  // NOTE: the array is flop-based and reset must force every entry to zero
  // asynchronously, so the memory is reset here rather than left uninitialised
  // as a RAM macro would be.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_busy) begin
      mem[clr_ptr] <= '0;
    end else begin
      // NOTE: with non-blocking assignments the last one scheduled wins, so
      // placing port B after port A gives B priority on a same-address write.
      if (wa_acc) mem[wa_addr] <= wa_data;
      if (wb_acc) mem[wb_addr] <= wb_data;
    end
  end

  // Combinational read ports.
  // NOTE: rd_data gets a full default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*DATA_W +: DATA_W] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
      if ((ZERO_REG != 0) && (rd_addr[i*ADDR_W +: ADDR_W] == '0)) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
      end
`ifdef REGFILE_BYPASS_EN
      // Forward same-cycle write data; B checked last so it wins a collision.
      // wa_acc/wb_acc are already low during a clear; reset also blocks it so
      // every port reads zero while reset is held.
      if (!reset && wa_acc && (wa_addr == rd_addr[i*ADDR_W +: ADDR_W])) begin
        rd_data[i*DATA_W +: DATA_W] = wa_data;
      end
      if (!reset && wb_acc && (wb_addr == rd_addr[i*ADDR_W +: ADDR_W])) begin
        rd_data[i*DATA_W +: DATA_W] = wb_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (default parameters).
// Directed scenarios plus randomised traffic, all compared against a
// behavioural model of the register file kept in this module.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic              wa_en, wb_en, clr_req;
  logic [AW-1:0]     wa_addr, wb_addr;
  logic [DW-1:0]     wa_data, wb_data;
  logic              wr_ready, clr_busy, clr_done, drop_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: array contents, remaining clear cycles, status flags.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left;
  bit            m_done;
  bit            m_drop;

  int busy_cycles;
  int done_cnt;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wa_en    (wa_en),
    .wa_addr  (wa_addr),
    .wa_data  (wa_data),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wr_ready (wr_ready),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .drop_err (drop_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rexp(input logic [AW-1:0] a);
    return (a == '0) ? '0 : m_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_left = 0;
    m_done = 1'b0;
    m_drop = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit done_next;
    done_next = 1'b0;
    if (m_left > 0) begin
      if (wa_en || wb_en) m_drop = 1'b1;
      m_mem[DEPTH - m_left] = '0;
      m_left--;
      if (m_left == 0) done_next = 1'b1;
    end else begin
      if (wa_en && wa_addr != '0) m_mem[wa_addr] = wa_data;
      if (wb_en && wb_addr != '0) m_mem[wb_addr] = wb_data;
      if (clr_req) m_left = DEPTH;
    end
    m_done = done_next;
  endtask

  task automatic step(input bit a_en, input logic [AW-1:0] a_ad, input logic [DW-1:0] a_d,
                      input bit b_en, input logic [AW-1:0] b_ad, input logic [DW-1:0] b_d,
                      input bit clr);
    wa_en = a_en; wa_addr = a_ad; wa_data = a_d;
    wb_en = b_en; wb_addr = b_ad; wb_data = b_d;
    clr_req = clr;
    model_edge();
    @(posedge clk);
    #1;
    wa_en = 1'b0; wb_en = 1'b0; clr_req = 1'b0;
    check("clr_busy", DW'(clr_busy), DW'(m_left > 0));
    check("clr_done", DW'(clr_done), DW'(m_done));
    check("drop_err", DW'(drop_err), DW'(m_drop));
    check("wr_ready", DW'(wr_ready), DW'(m_left == 0));
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic check_rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
    check("rd0", rd_data[DW-1:0], rexp(a0));
    check("rd1", rd_data[2*DW-1:DW], rexp(a1));
  endtask

  initial begin
    reset = 1'b1;
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    clr_req = 1'b0; rd_addr = '0;
    model_reset();
    #12 reset = 1'b0;

    // Mid-cycle reset wipes previously written entries without a clock.
    step(1'b1, 5'd1, 32'hAAAA5555, 1'b1, 5'd31, 32'h5555AAAA, 1'b0);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("rst_busy", DW'(clr_busy), '0);
    check("rst_drop", DW'(drop_err), '0);
    check("rst_done", DW'(clr_done), '0);
    check("rst_ready", DW'(wr_ready), DW'(1));
    check_rd2(5'd0, 5'd1);
    check_rd2(5'd31, 5'd0);
    check_rd2(5'd1, 5'd31);
    reset = 1'b0;

    // Dual write on one edge, read back on both ports.
    step(1'b1, 5'd5, 32'h12345678, 1'b1, 5'd9, 32'hDEADBEEF, 1'b0);
    check_rd2(5'd5, 5'd9);
    check("x5_const", rd_data[DW-1:0], 32'h12345678);
    check("x9_const", rd_data[2*DW-1:DW], 32'hDEADBEEF);

    // Same-address collision: port B wins.
    step(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b0);
    check_rd2(5'd7, 5'd7);
    check("x7_coll", rd_data[DW-1:0], 32'h22222222);

    // Write to hardwired zero entry is silently discarded.
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0, 1'b0);
    check_rd2(5'd0, 5'd0);
    check("x0_zero", rd_data[DW-1:0], '0);
    check("x0_nodrop", DW'(drop_err), '0);

    // Bulk clear with a dropped write in the middle of it.
    for (int n = 1; n < DEPTH; n++) begin
      step(1'b1, AW'(n), 32'h10000000 | n, 1'b0, '0, '0, 1'b0);
    end
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    busy_cycles = 0;
    done_cnt = 0;
    for (int c = 0; c < 100 && clr_busy; c++) begin
      busy_cycles++;
      if (busy_cycles == 16) begin
        check_rd2(5'd3, 5'd20);
        check("x3_mid", rd_data[DW-1:0], '0);
        check("x20_mid", rd_data[2*DW-1:DW], 32'h10000014);
      end
      if (busy_cycles == 2) step(1'b1, 5'd4, 32'hABCDEF00, 1'b0, '0, '0, 1'b0);
      else idle();
      done_cnt += int'(clr_done);
    end
    check("busy_len", DW'(busy_cycles), DW'(DEPTH));
    idle();
    done_cnt += int'(clr_done);
    check("done_cnt", DW'(done_cnt), DW'(1));
    check("drop_set", DW'(drop_err), DW'(1));
    for (int a = 0; a < DEPTH / 2; a++) begin
      check_rd2(AW'(a), AW'(a + DEPTH / 2));
      check("clr_zero", rd_data, '0);
    end
    check_rd2(5'd4, 5'd4);
    check("x4_dropped", rd_data[DW-1:0], '0);
    idle();
    check("drop_sticky", DW'(drop_err), DW'(1));

    // Randomised traffic: writes, collisions, occasional clears, drops.
    @(negedge clk);
    for (int c = 0; c < 300; c++) begin
      logic [AW-1:0] a_ad, b_ad;
      a_ad = AW'($urandom);
      b_ad = ($urandom_range(0, 3) == 0) ? a_ad : AW'($urandom);
      step(1'($urandom_range(0, 1)), a_ad, $urandom,
           1'($urandom_range(0, 1)), b_ad, $urandom,
           ($urandom_range(0, 99) < 3));
      check_rd2(AW'($urandom), AW'($urandom));
    end
    for (int c = 0; c < 40 && m_left > 0; c++) idle();

    // Reset 10 cycles into a clear aborts it with no done pulse.
    step(1'b1, 5'd12, 32'hCAFEF00D, 1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    for (int c = 0; c < 10; c++) idle();
    #1 reset = 1'b1;
    model_reset();
    #1;
    check("abort_busy", DW'(clr_busy), '0);
    check("abort_done", DW'(clr_done), '0);
    for (int a = 0; a < DEPTH / 2; a++) check_rd2(AW'(a), AW'(a + DEPTH / 2));
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      idle();
      done_cnt += int'(clr_done);
    end
    check("abort_nodone", DW'(done_cnt), '0);

`ifdef REGFILE_BYPASS_EN
    // Same-cycle forwarding of accepted write data.
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h87654321;
    rd_addr = {5'd0, 5'd3};
    #1;
    check("bypass", rd_data[DW-1:0], 32'h87654321);
    model_edge();
    @(posedge clk);
    #1;
    wa_en = 1'b0;
    check_rd2(5'd3, 5'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
